divide: RTL and testbench
=========================

DIVIDE -- requirements
Module: divide

Interface
REQ-001 Parameter OPCODE, default 4'b0101: ctr value that starts a division.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 ctr  input  4  opcode from control unit; a division starts when ctr equals OPCODE.
REQ-005 A  input  8  dividend.
REQ-006 B  input  8  divisor.
REQ-007 out  output  16  result: out[15:8] is the remainder, out[7:0] is the quotient; registered.
REQ-008 ctr1  output  1  done strobe; high for one cycle per completed operation.
REQ-009 busy  output  1  high while an iteration sequence is in progress.
REQ-010 div_zero  output  1  high when the last completed operation had B==0; registered.

Function
REQ-011 The state machine SHALL have two states: IDLE and CALC.
REQ-012 In IDLE, a clock edge with ctr==OPCODE and B!=0 SHALL capture A and B, clear the partial remainder, set the iteration counter to 7, set busy=1, and enter CALC.
REQ-013 In CALC, each edge SHALL perform one restoring step: shift {rem,quo} left 1, trial-subtract the divisor from rem, keep the difference and set quo[0]=1 if it is non-negative, else restore and set quo[0]=0.
REQ-014 Subtraction SHALL use a 9-bit trial width so that divisors of 128 or more are handled without overflow.
REQ-015 After the 8th CALC edge (counter reaching 0), the block SHALL write out={rem,quo}, div_zero=0, ctr1=1, busy=0, and return to IDLE.
REQ-016 Latency SHALL be 9 rising edges from the start edge to ctr1 high, fixed for all operands with B!=0.
REQ-017 In IDLE, a clock edge with ctr==OPCODE and B==0 SHALL write out={A,8'hFF}, div_zero=1, ctr1=1, and remain in IDLE; latency is 1 edge.
REQ-018 ctr==OPCODE while busy SHALL be ignored, with no restart and no queuing.
REQ-019 A and B changing during CALC SHALL not affect the result, because the operands are captured at the start edge.
REQ-020 ctr1 SHALL deassert on the edge after it asserts, unless a new divide-by-zero start occurs on that edge.
REQ-021 out and div_zero SHALL hold their values until the next completion.
REQ-022 Back-to-back operation: a start is accepted on the edge in which ctr1 is already high (the block is in IDLE).

Reset
REQ-023 When rst_n=0, the block SHALL immediately set state=IDLE, out=16'h0000, ctr1=0, busy=0, div_zero=0, and clear the counter and internal registers.
REQ-024 Reset during CALC SHALL abort the operation, produce no ctr1 pulse, and leave out=0.
REQ-025 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro DIV_SIGNED_EN.
- Defined: A and B are two's complement. The block divides the magnitudes; the quotient is negated if A[7]^B[7]; the remainder takes the sign of A. -128/-1 produces quotient 8'h80, remainder 8'h00. Sign fix-up is applied at the output write with no added latency. Divide-by-zero output is unchanged (REQ-017).
- Undefined: unsigned only; no sign logic is synthesized.

Verification
REQ-027 Unsigned: A=100, B=7, ctr=OPCODE for 1 cycle -> ctr1 high 9 edges later; out=16'h020E; div_zero=0.
REQ-028 Unsigned edge cases:
- A=255, B=1 -> out=16'h00FF.
- A=200, B=255 -> out=16'hC800.
- A=0, B=9 -> out=16'h0000.
REQ-029 Divide by zero: A=5, B=0 -> ctr1 and div_zero high after 1 edge; out=16'h05FF; busy never high.
REQ-030 Busy and operand stability:
- Start 100/7, reassert ctr=OPCODE with A=9, B=3 at edge 4, and also change A and B -> a single ctr1 pulse at edge 9; out=16'h020E.
REQ-031 Reset mid-operation: rst_n low at edge 5 of a divide -> all outputs 0 immediately; no ctr1 pulse; a new 100/7 started after reset gives 16'h020E.
REQ-032 DIV_SIGNED_EN:
- A=-7 (8'hF9), B=2 -> out=16'hFFFD.
- A=-128, B=-1 -> out=16'h0080.

Source files
------------

// File: rtl/divide.sv
// -----------------------------------------------------------------------------
// divide -- 8-bit / 8-bit restoring divider, one quotient bit per clock.
//
// A start (ctr == OPCODE while idle) captures the operands. Eight CALC cycles
// follow, and the result is written with a one-cycle ctr1 strobe. The total
// latency is 9 rising edges from the start edge. A zero divisor completes
// on the start edge with out = {A, 8'hFF} and div_zero = 1.
//
// Ports:
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset
//   ctr[3:0]  opcode from control unit; a start when equal to OPCODE
//   A[7:0]    dividend
//   B[7:0]    divisor
//   out[15:0] {remainder, quotient}, registered, held until next completion
//   ctr1      one-cycle done strobe
//   busy      high while the iteration sequence runs
//   div_zero  last completed operation had B == 0
//
// Optional feature: define DIV_SIGNED_EN for two's-complement operands.
// The divider core works on magnitudes. The sign fix-up is applied when the
// output is written, so it adds no cycles.
//
// State table:
//   state | meaning
//   IDLE  | waiting for a start; handles divide-by-zero in one edge
//   CALC  | one restoring step per edge, cnt counts 7 down to 0
// -----------------------------------------------------------------------------
module divide #(
    parameter logic [3:0] OPCODE = 4'b0101
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ctr,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] out,
    output logic        ctr1,
    output logic        busy,
    output logic        div_zero
);

    typedef enum logic {IDLE, CALC} state_t;

    state_t      state, state_nxt;
    logic [7:0]  rem, rem_nxt;
    logic [7:0]  quo, quo_nxt;
    logic [7:0]  dvs, dvs_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [15:0] out_nxt;
    logic        ctr1_nxt, busy_nxt, dz_nxt;

    logic [8:0]  trial;
    logic [9:0]  diff;
    logic        fits;
    logic [7:0]  rem_step, quo_step;
    logic [7:0]  a_mag, b_mag;
    logic [7:0]  rem_fix, quo_fix;

`ifdef DIV_SIGNED_EN
    logic        neg_q, neg_q_nxt;
    logic        neg_r, neg_r_nxt;
`endif

    // One restoring step. The 9-bit trial value (rem shifted plus the next
    // dividend bit) can exceed 255 when the divisor is 128 or more, so the
    // subtraction is carried out one bit wider and its MSB is the borrow.
    always_comb begin
        trial    = {rem, quo[7]};
        diff     = {1'b0, trial} - {2'b00, dvs};
        fits     = ~diff[9];
        rem_step = fits ? diff[7:0] : trial[7:0];
        quo_step = {quo[6:0], fits};
    end

`ifdef DIV_SIGNED_EN
    always_comb begin
        a_mag   = A[7] ? (~A + 8'd1) : A;
        b_mag   = B[7] ? (~B + 8'd1) : B;
        quo_fix = neg_q ? (~quo_step + 8'd1) : quo_step;
        rem_fix = neg_r ? (~rem_step + 8'd1) : rem_step;
    end
`else
    always_comb begin
        a_mag   = A;
        b_mag   = B;
        quo_fix = quo_step;
        rem_fix = rem_step;
    end
`endif

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        quo_nxt   = quo;
        dvs_nxt   = dvs;
        cnt_nxt   = cnt;
        out_nxt   = out;
        ctr1_nxt  = 1'b0;
        busy_nxt  = busy;
        dz_nxt    = div_zero;
`ifdef DIV_SIGNED_EN
        neg_q_nxt = neg_q;
        neg_r_nxt = neg_r;
`endif
        case (state)
            IDLE: begin
                if (ctr == OPCODE) begin
                    if (B == 8'd0) begin
                        out_nxt  = {A, 8'hFF};
                        dz_nxt   = 1'b1;
                        ctr1_nxt = 1'b1;
                    end else begin
                        // quo starts out holding the dividend and is shifted
                        // into rem one bit per step.
                        quo_nxt   = a_mag;
                        dvs_nxt   = b_mag;
                        rem_nxt   = 8'd0;
                        cnt_nxt   = 3'd7;
                        busy_nxt  = 1'b1;
                        state_nxt = CALC;
`ifdef DIV_SIGNED_EN
                        neg_q_nxt = A[7] ^ B[7];
                        neg_r_nxt = A[7];
`endif
                    end
                end
            end
            CALC: begin
                rem_nxt = rem_step;
                quo_nxt = quo_step;
                if (cnt == 3'd0) begin
                    out_nxt   = {rem_fix, quo_fix};
                    dz_nxt    = 1'b0;
                    ctr1_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rem      <= 8'd0;
            quo      <= 8'd0;
            dvs      <= 8'd0;
            cnt      <= 3'd0;
            out      <= 16'h0000;
            ctr1     <= 1'b0;
            busy     <= 1'b0;
            div_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            rem      <= rem_nxt;
            quo      <= quo_nxt;
            dvs      <= dvs_nxt;
            cnt      <= cnt_nxt;
            out      <= out_nxt;
            ctr1     <= ctr1_nxt;
            busy     <= busy_nxt;
            div_zero <= dz_nxt;
`ifdef DIV_SIGNED_EN
            neg_q    <= neg_q_nxt;
            neg_r    <= neg_r_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_divide.sv
// -----------------------------------------------------------------------------
// tb_divide -- self-checking bench for divide.
// A cycle-level reference model built on plain / and % arithmetic predicts
// out, ctr1, busy and div_zero. These predictions are compared on every
// falling edge. Directed cases with literal expectations pin the model, and
// a long randomized phase follows them. DIV_SIGNED_EN selects signed expectations.
// -----------------------------------------------------------------------------
module tb_divide;

    localparam logic [3:0] OPC = 4'b0101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ctr = 4'd0;
    logic [7:0]  A = 8'd0;
    logic [7:0]  B = 8'd0;
    logic [15:0] out;
    logic        ctr1, busy, div_zero;

    int checks = 0;
    int errors = 0;

    divide #(.OPCODE(OPC)) dut (
        .clk(clk), .rst_n(rst_n), .ctr(ctr), .A(A), .B(B),
        .out(out), .ctr1(ctr1), .busy(busy), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_div(input logic [7:0] a, input logic [7:0] b);
`ifdef DIV_SIGNED_EN
        int sa, sb, q, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[7:0], q[7:0]};
`else
        logic [7:0] q, r;
        q = a / b;
        r = a % b;
        return {r, q};
`endif
    endfunction

    // Reference model: the latency is counted in edges. Results come from ref_div.
    logic [15:0] m_out = 16'h0, pend = 16'h0;
    logic        m_ctr1 = 1'b0, m_busy = 1'b0, m_dz = 1'b0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out  <= 16'h0;
            m_ctr1 <= 1'b0;
            m_busy <= 1'b0;
            m_dz   <= 1'b0;
            m_left <= 0;
        end else begin
            m_ctr1 <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_out  <= pend;
                    m_ctr1 <= 1'b1;
                    m_busy <= 1'b0;
                    m_dz   <= 1'b0;
                end
            end else if (ctr == OPC) begin
                if (B == 8'd0) begin
                    m_out  <= {A, 8'hFF};
                    m_dz   <= 1'b1;
                    m_ctr1 <= 1'b1;
                end else begin
                    pend   <= ref_div(A, B);
                    m_left <= 8;
                    m_busy <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("model_out", out, m_out);
        check("model_ctr1", {15'd0, ctr1}, {15'd0, m_ctr1});
        check("model_busy", {15'd0, busy}, {15'd0, m_busy});
        check("model_div_zero", {15'd0, div_zero}, {15'd0, m_dz});
    end

    // Starts one operation, scrambles the operands after the start edge,
    // and waits (bounded) for ctr1. n is the edge count from the start edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int n, output logic [15:0] o, output logic dz);
        @(negedge clk);
        ctr = OPC; A = a; B = b;
        @(negedge clk);
        ctr = 4'd0; A = 8'($urandom); B = 8'($urandom);
        n = 1;
        while (!ctr1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        o  = out;
        dz = div_zero;
    endtask

    task automatic directed(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] exp_out, input int exp_n, input logic exp_dz);
        int n;
        logic [15:0] o;
        logic dz;
        run_op(a, b, n, o, dz);
        check({name, "_latency"}, 16'(n), 16'(exp_n));
        check({name, "_out"}, o, exp_out);
        check({name, "_dz"}, {15'd0, dz}, {15'd0, exp_dz});
    endtask

    initial begin
        int n, pulses, at;
        logic [15:0] o;

        repeat (2) @(negedge clk);
        check("reset_out", out, 16'h0000);
        check("reset_flags", {13'd0, ctr1, busy, div_zero}, 16'h0000);

        // First start is issued on the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b1; ctr = OPC; A = 8'd100; B = 8'd7;
        @(negedge clk);
        ctr = 4'd0;
        n = 1;
        while (!ctr1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("first_latency", 16'(n), 16'd9);
        check("first_out", out, 16'h020E);

        directed("div_100_7", 8'd100, 8'd7, 16'h020E, 9, 1'b0);
        directed("div_by_zero", 8'd5, 8'd0, 16'h05FF, 1, 1'b1);
        directed("div_0_9", 8'd0, 8'd9, 16'h0000, 9, 1'b0);
`ifdef DIV_SIGNED_EN
        directed("sdiv_m7_2", 8'hF9, 8'd2, 16'hFFFD, 9, 1'b0);
        directed("sdiv_m128_m1", 8'h80, 8'hFF, 16'h0080, 9, 1'b0);
        directed("sdiv_200_255", 8'd200, 8'd255, 16'h0038, 9, 1'b0);
`else
        directed("div_255_1", 8'd255, 8'd1, 16'h00FF, 9, 1'b0);
        directed("div_200_255", 8'd200, 8'd255, 16'hC800, 9, 1'b0);
`endif

        // A start re-requested while busy and changed operands must be ignored.
        @(negedge clk);
        ctr = OPC; A = 8'd100; B = 8'd7;
        @(negedge clk);
        ctr = 4'd0;
        pulses = 0; at = 0; o = 16'h0;
        for (int k = 2; k <= 14; k++) begin
            if (k == 4) begin ctr = OPC; A = 8'd9; B = 8'd3; end
            if (k == 7) ctr = 4'd0;
            @(negedge clk);
            if (ctr1) begin pulses++; at = k; o = out; end
        end
        check("busy_pulses", 16'(pulses), 16'd1);
        check("busy_pulse_edge", 16'(at), 16'd9);
        check("busy_out", o, 16'h020E);

        // Reset in the middle of an operation.
        @(negedge clk);
        ctr = OPC; A = 8'd100; B = 8'd7;
        @(negedge clk);
        ctr = 4'd0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out", out, 16'h0000);
        check("midrst_flags", {13'd0, ctr1, busy, div_zero}, 16'h0000);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (ctr1) pulses++;
        end
        check("midrst_no_pulse", 16'(pulses), 16'd0);
        rst_n = 1'b1;
        directed("after_rst", 8'd100, 8'd7, 16'h020E, 9, 1'b0);

        // Randomized traffic; the per-cycle comparison against the model does the checking.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ctr = ($urandom_range(0, 2) == 0) ? OPC : 4'($urandom_range(0, 15));
            A   = 8'($urandom);
            B   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        ctr = 4'd0;
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
